// File: rtl/prim_arbiter_wrr.sv
// prim_arbiter_wrr
//    Packet-aware weighted round-robin / fixed-priority arbiter. N requesters
//    compete for one sink. Once a multi-beat packet starts, its port keeps the
//    grant until the beat flagged by last_i is accepted. In weighted mode a
//    port may send up to weight_i[port] packets back to back before priority
//    moves on to the next higher index.
//
//    Optional build macro: PRIM_ARBITER_WRR_STARVE_EN adds per-port wait
//    counters that drive starve_o. Without it, starve_o is tied to 0.
//
// Ports
//    clk_i     clock, rising edge
//    rst_ni    asynchronous active-low reset
//    req_i     [N]      per-port request
//    data_i    [N*DW]   per-port data, port i at bits [i*DW +: DW]
//    last_i    [N]      per-port last-beat flag
//    weight_i  [N*WW]   packets per turn, port i at bits [i*WW +: WW]; 0 acts as 1
//    mode_i    0 = weighted round robin, 1 = fixed priority (lowest index)
//    gnt_o     [N]      one-hot grant, only when the beat is accepted
//    idx_o     index of the current winner (0 when nothing requests)
//    valid_o   winner request valid
//    data_o    [DW]     winner data (0 when nothing requests)
//    ready_i   sink ready
//    starve_o  some pending request has waited StarveLimit cycles or more
//
// State | meaning
// ARB   | choose a winner each cycle from mask/req_i/mode_i
// LOCK  | mid-packet, grant pinned to r_lock_idx until its last beat is accepted

module prim_arbiter_wrr #(
   parameter int N           = 8,
   parameter int DW          = 32,
   parameter int WW          = 4,
   parameter int EnDataPort  = 1,
   parameter int StarveLimit = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [N-1:0]          req_i,
   input  logic [N*DW-1:0]       data_i,
   input  logic [N-1:0]          last_i,
   input  logic [N*WW-1:0]       weight_i,
   input  logic                  mode_i,
   output logic [N-1:0]          gnt_o,
   output logic [$clog2(N)-1:0]  idx_o,
   output logic                  valid_o,
   output logic [DW-1:0]         data_o,
   input  logic                  ready_i,
   output logic                  starve_o
);

   localparam int IW = $clog2(N);

   typedef enum logic {ARB, LOCK} state_e;

   state_e          r_state, w_state_nxt;
   logic [N-1:0]    r_mask, w_mask_nxt;
   logic [WW-1:0]   r_cnt, w_cnt_nxt;
   logic [IW-1:0]   r_owner, w_owner_nxt;
   logic [IW-1:0]   r_lock_idx, w_lock_nxt;

   logic [N-1:0]    w_masked;
   logic [IW-1:0]   w_winner;
   logic            w_valid;
   logic            w_accept;
   logic            w_last;
   logic [N-1:0]    w_ge_mask;
   logic [N-1:0]    w_gt_mask;
   logic [WW-1:0]   w_weight;
   logic [WW:0]     w_weight_eff;
   logic [WW-1:0]   w_base;
   logic [WW:0]     w_base_p1;

   function automatic logic [IW-1:0] lowest(input logic [N-1:0] v);
      logic [IW-1:0] r;
      r = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (v[i]) r = IW'(i);
      end
      return r;
   endfunction

   always_comb begin
      w_masked = r_mask & req_i;
      w_winner = '0;
      w_valid  = 1'b0;
      if (r_state == LOCK) begin
         w_winner = r_lock_idx;
         w_valid  = req_i[r_lock_idx];
      end else begin
         w_valid = |req_i;
         if (mode_i || (w_masked == '0)) w_winner = lowest(req_i);
         else                            w_winner = lowest(w_masked);
      end
   end

   assign w_accept     = w_valid & ready_i;
   assign w_last       = last_i[w_winner];
   assign w_ge_mask    = {N{1'b1}} << w_winner;
   assign w_gt_mask    = {w_ge_mask[N-2:0], 1'b0};
   assign w_weight     = weight_i[int'(w_winner)*WW +: WW];
   assign w_weight_eff = (w_weight == '0) ? (WW+1)'(1) : {1'b0, w_weight};
   // A port that did not own the previous packet starts its turn fresh, so
   // this packet is the first one counted against its weight.
   assign w_base       = (w_winner == r_owner) ? r_cnt : '0;
   assign w_base_p1    = {1'b0, w_base} + (WW+1)'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_mask_nxt  = r_mask;
      w_cnt_nxt   = r_cnt;
      w_owner_nxt = r_owner;
      w_lock_nxt  = r_lock_idx;

      case (r_state)
         ARB: begin
            if (w_accept && !w_last) begin
               w_state_nxt = LOCK;
               w_lock_nxt  = w_winner;
            end
         end
         LOCK: begin
            if (w_accept && w_last) w_state_nxt = ARB;
         end
         default: w_state_nxt = ARB;
      endcase

      if (mode_i) begin
         w_cnt_nxt = '0;
      end else if (w_accept && w_last) begin
         w_owner_nxt = w_winner;
         if (w_base_p1 < w_weight_eff) begin
            w_cnt_nxt  = w_base_p1[WW-1:0];
            w_mask_nxt = w_ge_mask;
         end else begin
            w_cnt_nxt  = '0;
            w_mask_nxt = w_gt_mask;
         end
      end else if ((r_state == ARB) && w_valid && !ready_i) begin
         // Stalled winner stays first so a newly arriving lower port cannot
         // overtake it before its beat is taken.
         w_mask_nxt = w_ge_mask;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ARB;
         r_mask     <= '0;
         r_cnt      <= '0;
         r_owner    <= '0;
         r_lock_idx <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_mask     <= w_mask_nxt;
         r_cnt      <= w_cnt_nxt;
         r_owner    <= w_owner_nxt;
         r_lock_idx <= w_lock_nxt;
      end
   end

   // Grant is combinational from req_i/ready_i, so it is gated by reset
   // to keep it quiet while rst_ni is low.
   assign gnt_o   = (w_accept && rst_ni) ? (N'(1) << w_winner) : '0;
   assign valid_o = w_valid;
   assign idx_o   = (|req_i) ? w_winner : '0;

   if (EnDataPort != 0) begin : g_data
      assign data_o = (|req_i) ? data_i[int'(w_winner)*DW +: DW] : '0;
   end else begin : g_nodata
      assign data_o = '1;
   end

`ifdef PRIM_ARBITER_WRR_STARVE_EN
   logic [15:0] r_starve_cnt [N];
   logic        w_starve;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N; i++) r_starve_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (req_i[i] && !gnt_o[i]) begin
               if (r_starve_cnt[i] != 16'hFFFF) r_starve_cnt[i] <= r_starve_cnt[i] + 16'd1;
            end else begin
               r_starve_cnt[i] <= '0;
            end
         end
      end
   end

   always_comb begin
      w_starve = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (int'({16'd0, r_starve_cnt[i]}) >= StarveLimit) w_starve = 1'b1;
      end
   end

   assign starve_o = w_starve & rst_ni;
`else
   logic w_unused_starve_limit;
   assign w_unused_starve_limit = (StarveLimit != 0);
   assign starve_o = 1'b0;
`endif

endmodule

// File: tb/tb_prim_arbiter_wrr.sv
module tb_prim_arbiter_wrr;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int WW = 4;
`ifdef PRIM_ARBITER_WRR_STARVE_EN
   localparam bit STARVE_ON = 1'b1;
`else
   localparam bit STARVE_ON = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*DW-1:0] data;
   logic [N-1:0]    last;
   logic [N*WW-1:0] weight;
   logic            mode;
   logic [N-1:0]    gnt;
   logic [1:0]      idx;
   logic            valid;
   logic [DW-1:0]   dout;
   logic            ready;
   logic            starve;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   prim_arbiter_wrr #(
      .N(N), .DW(DW), .WW(WW), .EnDataPort(1), .StarveLimit(4)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .data_i(data), .last_i(last),
      .weight_i(weight), .mode_i(mode), .gnt_o(gnt), .idx_o(idx),
      .valid_o(valid), .data_o(dout), .ready_i(ready), .starve_o(starve)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] exp030 [5];
   logic [1:0] exp031 [8];

   initial begin
      exp030 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp031 = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};

      data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      rst_n  = 1'b0;
      req    = 4'b1111;
      last   = 4'b1111;
      ready  = 1'b1;
      mode   = 1'b0;
      weight = {4'd1, 4'd1, 4'd1, 4'd1};
      #2;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_starve", 32'(starve), 32'h0);
      tick();
      chk("rst_gnt_edge", 32'(gnt), 32'h0);
      rst_n = 1'b1;
      #1;

      // plain round robin, all weights 1
      chk("rr_data0", 32'(dout), 32'hA0);
      chk("rr_idx0", 32'(idx), 32'h0);
      for (int i = 0; i < 5; i++) begin
         chk("rr_gnt", 32'(gnt), 32'(exp030[i]));
         tick();
      end

      // port 0 weight 3, ports 0 and 1 requesting
      weight = {4'd1, 4'd1, 4'd1, 4'd3};
      req    = 4'b0011;
      rst_n  = 1'b0;
      #1;
      tick();
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         chk("wrr_idx", 32'(idx), 32'(exp031[i]));
         chk("wrr_gnt", 32'(gnt), 32'(4'b0001 << exp031[i]));
         tick();
      end

      // 3-beat packet on port 2 while port 0 waits; mode flip mid-packet
      weight = {4'd1, 4'd1, 4'd1, 4'd1};
      req    = 4'b0101;
      last   = 4'b1011;
      #1;
      chk("lock_b1", 32'(gnt), 32'h4);
      tick();
      mode = 1'b1;
      #1;
      chk("lock_b2", 32'(gnt), 32'h4);
      chk("lock_idx", 32'(idx), 32'h2);
      tick();
      mode = 1'b0;
      last = 4'b1111;
      #1;
      chk("lock_b3", 32'(gnt), 32'h4);
      tick();
      chk("lock_after", 32'(gnt), 32'h1);
      tick();

      // backpressure: port 1 stalls, port 0 arrives, port 1 must still win
      req = 4'b0010;
      #1;
      chk("bp_prep", 32'(gnt), 32'h2);
      tick();
      ready = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_idx", 32'(idx), 32'h1);
         chk("bp_gnt", 32'(gnt), 32'h0);
         tick();
      end
      req = 4'b0011;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("bp_hold_idx", 32'(idx), 32'h1);
         chk("bp_hold_valid", 32'(valid), 32'h1);
         tick();
      end
      ready = 1'b1;
      #1;
      chk("bp_acc", 32'(gnt), 32'h2);
      tick();
      chk("bp_next", 32'(gnt), 32'h1);
      tick();

      // fixed priority
      mode = 1'b1;
      req  = 4'b1010;
      #1;
      for (int k = 0; k < 6; k++) begin
         chk("fp_gnt", 32'(gnt), 32'h2);
         chk("fp_starve", 32'(starve), 32'(STARVE_ON && (k >= 4)));
         tick();
      end
      req = 4'b0011;
      #1;
      chk("fp_low", 32'(gnt), 32'h1);
      tick();
      chk("fp_low2", 32'(gnt), 32'h1);
      tick();

      // reset in the middle of a locked packet
      mode = 1'b0;
      req  = 4'b0100;
      last = 4'b1011;
      #1;
      chk("rl_start", 32'(gnt), 32'h4);
      tick();
      req = 4'b0101;
      #1;
      chk("rl_locked", 32'(gnt), 32'h4);
      rst_n = 1'b0;
      #1;
      chk("rl_rst_gnt", 32'(gnt), 32'h0);
      tick();
      chk("rl_rst_gnt2", 32'(gnt), 32'h0);
      rst_n = 1'b1;
      #1;
      chk("rl_post_gnt", 32'(gnt), 32'h1);
      chk("rl_post_idx", 32'(idx), 32'h0);

      // idle outputs
      req  = 4'b0000;
      last = 4'b1111;
      #1;
      chk("idle_idx", 32'(idx), 32'h0);
      chk("idle_data", 32'(dout), 32'h0);
      chk("idle_valid", 32'(valid), 32'h0);
      chk("idle_gnt", 32'(gnt), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
